// File: rtl/ex_bitfield_sched.sv
// Two-requester scheduler for a shared EXT/INS bitfield unit.
// Each issue pipe owns a holding register (captured request) and a result
// register (held response). At most one waiting pipe is granted the unit per
// cycle; contested grants alternate via a round-robin pointer.
module ex_bitfield_sched #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_is_ins,
    input  logic [31:0]      req0_inst,
    input  logic [31:0]      req0_rs,
    input  logic [31:0]      req0_rt,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_is_ins,
    input  logic [31:0]      req1_inst,
    input  logic [31:0]      req1_rs,
    input  logic [31:0]      req1_rt,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [31:0]      resp0_data,
    output logic [TAG_W-1:0] resp0_tag,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [31:0]      resp1_data,
    output logic [TAG_W-1:0] resp1_tag,
    output logic             bf_is_ins,
    output logic [31:0]      bf_inst,
    output logic [31:0]      bf_in1,
    output logic [31:0]      bf_in2,
    input  logic [31:0]      bf_result,
    output logic [15:0]      conflict_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r   [2];
    state_t           state_nxt [2];

    logic             hold_is_ins_r [2];
    logic [31:0]      hold_inst_r   [2];
    logic [31:0]      hold_rs_r     [2];
    logic [31:0]      hold_rt_r     [2];
    logic [TAG_W-1:0] hold_tag_r    [2];
    logic [31:0]      res_data_r    [2];
    logic [TAG_W-1:0] res_tag_r     [2];

    logic             ptr_r;
    logic [15:0]      cnt_r;

    logic [1:0]       req_valid;
    logic [1:0]       resp_ready;
    logic [1:0]       ready_s;
    logic [1:0]       accept_s;
    logic [1:0]       waiting_s;
    logic [1:0]       grant_s;
    logic             both_wait_s;

    logic             in_is_ins [2];
    logic [31:0]      in_inst   [2];
    logic [31:0]      in_rs     [2];
    logic [31:0]      in_rt     [2];
    logic [TAG_W-1:0] in_tag    [2];

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};
    assign in_is_ins[0] = req0_is_ins;
    assign in_is_ins[1] = req1_is_ins;
    assign in_inst[0]   = req0_inst;
    assign in_inst[1]   = req1_inst;
    assign in_rs[0]     = req0_rs;
    assign in_rs[1]     = req1_rs;
    assign in_rt[0]     = req0_rt;
    assign in_rt[1]     = req1_rt;
    assign in_tag[0]    = req0_tag;
    assign in_tag[1]    = req1_tag;

    // Handshake readiness, waiting flags and the single-winner grant.
    // Flush and reset both suppress acceptance and grants.
    always_comb begin
        ready_s     = 2'b00;
        waiting_s   = 2'b00;
        grant_s     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ready_s[i]   = ((state_r[i] == ST_IDLE) ||
                            ((state_r[i] == ST_DONE) && resp_ready[i])) &&
                           !flush && rst_n;
            waiting_s[i] = (state_r[i] == ST_WAIT);
        end
        both_wait_s = waiting_s[0] && waiting_s[1];
        if (!rst_n || flush) begin
            grant_s = 2'b00;
        end else if (both_wait_s) begin
            grant_s = ptr_r ? 2'b10 : 2'b01;
        end else begin
            grant_s = waiting_s;
        end
        accept_s = req_valid & ready_s;
    end

    // Shared-unit operand mux: granted pipe's holding register, else zero.
    always_comb begin
        bf_is_ins = 1'b0;
        bf_inst   = 32'd0;
        bf_in1    = 32'd0;
        bf_in2    = 32'd0;
        if (grant_s[0]) begin
            bf_is_ins = hold_is_ins_r[0];
            bf_inst   = hold_inst_r[0];
            bf_in1    = hold_rs_r[0];
            bf_in2    = hold_rt_r[0];
        end else if (grant_s[1]) begin
            bf_is_ins = hold_is_ins_r[1];
            bf_inst   = hold_inst_r[1];
            bf_in1    = hold_rs_r[1];
            bf_in2    = hold_rt_r[1];
        end else begin
            bf_is_ins = 1'b0;
        end
    end

    // Per-pipe next-state logic: IDLE -> WAIT on accept, WAIT -> DONE on
    // grant, DONE drains on response handshake (back-to-back accept allowed).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state_r[i];
            if (flush) begin
                state_nxt[i] = ST_IDLE;
            end else begin
                case (state_r[i])
                    ST_IDLE: begin
                        if (accept_s[i]) state_nxt[i] = ST_WAIT;
                        else             state_nxt[i] = ST_IDLE;
                    end
                    ST_WAIT: begin
                        if (grant_s[i]) state_nxt[i] = ST_DONE;
                        else            state_nxt[i] = ST_WAIT;
                    end
                    ST_DONE: begin
                        if (resp_ready[i]) state_nxt[i] = accept_s[i] ? ST_WAIT : ST_IDLE;
                        else               state_nxt[i] = ST_DONE;
                    end
                    default: state_nxt[i] = ST_IDLE;
                endcase
            end
        end
    end

    // State, holding/result registers, round-robin pointer and conflict counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_r[i]       <= ST_IDLE;
                hold_is_ins_r[i] <= 1'b0;
                hold_inst_r[i]   <= 32'd0;
                hold_rs_r[i]     <= 32'd0;
                hold_rt_r[i]     <= 32'd0;
                hold_tag_r[i]    <= '0;
                res_data_r[i]    <= 32'd0;
                res_tag_r[i]     <= '0;
            end
            ptr_r <= 1'b0;
            cnt_r <= 16'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_r[i] <= state_nxt[i];
                if (accept_s[i]) begin
                    hold_is_ins_r[i] <= in_is_ins[i];
                    hold_inst_r[i]   <= in_inst[i];
                    hold_rs_r[i]     <= in_rs[i];
                    hold_rt_r[i]     <= in_rt[i];
                    hold_tag_r[i]    <= in_tag[i];
                end
                if (grant_s[i]) begin
                    res_data_r[i] <= bf_result;
                    res_tag_r[i]  <= hold_tag_r[i];
                end
            end
            if (!flush && both_wait_s) begin
                ptr_r <= ~ptr_r;
                if (cnt_r != 16'hFFFF) cnt_r <= cnt_r + 16'd1;
            end
        end
    end

    assign req0_ready   = ready_s[0];
    assign req1_ready   = ready_s[1];
    assign resp0_valid  = (state_r[0] == ST_DONE);
    assign resp1_valid  = (state_r[1] == ST_DONE);
    assign resp0_data   = res_data_r[0];
    assign resp1_data   = res_data_r[1];
    assign resp0_tag    = res_tag_r[0];
    assign resp1_tag    = res_tag_r[1];
    assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_ex_bitfield_sched.sv
// Directed bench for ex_bitfield_sched with a behavioural EXT/INS unit on bf_*.
module tb_ex_bitfield_sched;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, flush;
    logic             req0_valid, req0_ready, req0_is_ins;
    logic [31:0]      req0_inst, req0_rs, req0_rt;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready, req1_is_ins;
    logic [31:0]      req1_inst, req1_rs, req1_rt;
    logic [TAG_W-1:0] req1_tag;
    logic             resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0]      resp0_data, resp1_data;
    logic [TAG_W-1:0] resp0_tag, resp1_tag;
    logic             bf_is_ins;
    logic [31:0]      bf_inst, bf_in1, bf_in2, bf_result;
    logic [15:0]      conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] EXT_INST = 32'h0000_3900; // msbd=7, lsb=4
    localparam logic [31:0] INS_INST = 32'h0000_7A00; // msb=15, lsb=8

    always #5 clk = ~clk;

    ex_bitfield_sched #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_is_ins(req0_is_ins),
        .req0_inst(req0_inst), .req0_rs(req0_rs), .req0_rt(req0_rt), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_is_ins(req1_is_ins),
        .req1_inst(req1_inst), .req1_rs(req1_rs), .req1_rt(req1_rt), .req1_tag(req1_tag),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .resp0_tag(resp0_tag),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .resp1_tag(resp1_tag),
        .bf_is_ins(bf_is_ins), .bf_inst(bf_inst), .bf_in1(bf_in1), .bf_in2(bf_in2),
        .bf_result(bf_result), .conflict_cnt(conflict_cnt)
    );

    // Behavioural EXT/INS unit (MIPS semantics).
    function automatic logic [31:0] bf_model(input logic ins, input logic [31:0] inst,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [5:0]  msb, lsb, w;
        logic [63:0] m;
        msb = {1'b0, inst[15:11]};
        lsb = {1'b0, inst[10:6]};
        if (!ins) begin
            w = msb + 6'd1;
            m = (64'd1 << w) - 64'd1;
            return (a >> lsb) & m[31:0];
        end else if (msb >= lsb) begin
            w = msb - lsb + 6'd1;
            m = ((64'd1 << w) - 64'd1) << lsb;
            return (b & ~m[31:0]) | ((a << lsb) & m[31:0]);
        end else begin
            return b;
        end
    endfunction

    assign bf_result = bf_model(bf_is_ins, bf_inst, bf_in1, bf_in2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic ins, input logic [31:0] inst, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [TAG_W-1:0] tag);
        req0_valid = 1'b1; req0_is_ins = ins; req0_inst = inst;
        req0_rs = rs; req0_rt = rt; req0_tag = tag;
    endtask

    task automatic drive1(input logic ins, input logic [31:0] inst, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [TAG_W-1:0] tag);
        req1_valid = 1'b1; req1_is_ins = ins; req1_inst = inst;
        req1_rs = rs; req1_rt = rt; req1_tag = tag;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        req0_valid = 1'b0; req0_is_ins = 1'b0; req0_inst = 32'd0; req0_rs = 32'd0;
        req0_rt = 32'd0; req0_tag = '0;
        req1_valid = 1'b0; req1_is_ins = 1'b0; req1_inst = 32'd0; req1_rs = 32'd0;
        req1_rt = 32'd0; req1_tag = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        tick();
        tick();
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        chk("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
        chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
        chk("rst_bf_inst", bf_inst, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_req0_ready", {31'd0, req0_ready}, 32'd1);

        // Pipe 0 EXT, uncontested.
        drive0(1'b0, EXT_INST, 32'h1234_5678, 32'd0, 4'd3);
        tick();
        req0_valid = 1'b0;
        chk("ext_wait_valid", {31'd0, resp0_valid}, 32'd0);
        chk("ext_bf_inst", bf_inst, EXT_INST);
        chk("ext_bf_in1", bf_in1, 32'h1234_5678);
        tick();
        chk("ext_resp_valid", {31'd0, resp0_valid}, 32'd1);
        chk("ext_resp_data", resp0_data, 32'h0000_0067);
        chk("ext_resp_tag", {28'd0, resp0_tag}, 32'd3);
        chk("ext_bf_idle", bf_inst, 32'd0);
        tick();
        chk("ext_drained", {31'd0, resp0_valid}, 32'd0);

        // Pipe 1 INS, uncontested.
        drive1(1'b1, INS_INST, 32'h0000_00AB, 32'hFFFF_FFFF, 4'd5);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("ins_resp_valid", {31'd0, resp1_valid}, 32'd1);
        chk("ins_resp_data", resp1_data, 32'hFFFF_ABFF);
        chk("ins_resp_tag", {28'd0, resp1_tag}, 32'd5);
        tick();

        // Contention round 1: pipe 0 wins.
        drive0(1'b0, EXT_INST, 32'h1234_5678, 32'd0, 4'd1);
        drive1(1'b1, INS_INST, 32'h0000_00AB, 32'hFFFF_FFFF, 4'd2);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("c1_grant_p0", {31'd0, bf_is_ins}, 32'd0);
        tick();
        chk("c1_resp0_valid", {31'd0, resp0_valid}, 32'd1);
        chk("c1_resp1_wait", {31'd0, resp1_valid}, 32'd0);
        chk("c1_cnt", {16'd0, conflict_cnt}, 32'd1);
        chk("c1_grant_p1", {31'd0, bf_is_ins}, 32'd1);
        tick();
        chk("c1_resp1_valid", {31'd0, resp1_valid}, 32'd1);
        chk("c1_resp1_data", resp1_data, 32'hFFFF_ABFF);
        chk("c1_resp0_gone", {31'd0, resp0_valid}, 32'd0);
        tick();

        // Contention round 2: pipe 1 wins.
        drive0(1'b0, EXT_INST, 32'h1234_5678, 32'd0, 4'd1);
        drive1(1'b1, INS_INST, 32'h0000_00AB, 32'hFFFF_FFFF, 4'd2);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("c2_grant_p1", {31'd0, bf_is_ins}, 32'd1);
        tick();
        chk("c2_resp1_valid", {31'd0, resp1_valid}, 32'd1);
        chk("c2_resp0_wait", {31'd0, resp0_valid}, 32'd0);
        chk("c2_cnt", {16'd0, conflict_cnt}, 32'd2);
        tick();
        chk("c2_resp0_valid", {31'd0, resp0_valid}, 32'd1);
        chk("c2_resp0_data", resp0_data, 32'h0000_0067);
        tick();

        // Throughput: back-to-back requests on pipe 0.
        drive0(1'b0, EXT_INST, 32'h1234_5678, 32'd0, 4'd7);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tput_resp0_valid", {31'd0, resp0_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        req0_valid = 1'b0;
        tick();
        chk("tput_idle", {31'd0, resp0_valid}, 32'd0);

        // Backpressure on pipe 0 while pipe 1 runs.
        resp0_ready = 1'b0;
        drive0(1'b0, EXT_INST, 32'h1234_5678, 32'd0, 4'd4);
        tick();
        req0_valid = 1'b0;
        tick();
        drive1(1'b1, INS_INST, 32'h0000_00AB, 32'hFFFF_FFFF, 4'd6);
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_resp0_valid", {31'd0, resp0_valid}, 32'd1);
            chk("bp_resp0_data", resp0_data, 32'h0000_0067);
            chk("bp_resp0_tag", {28'd0, resp0_tag}, 32'd4);
            chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
            if (i == 2) begin
                chk("bp_resp1_valid", {31'd0, resp1_valid}, 32'd1);
                chk("bp_resp1_data", resp1_data, 32'hFFFF_ABFF);
                chk("bp_resp1_tag", {28'd0, resp1_tag}, 32'd6);
            end
            tick();
            req1_valid = 1'b0;
        end
        req0_valid = 1'b0;
        resp0_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, resp0_valid}, 32'd0);

        // Flush with pipe 0 WAIT and pipe 1 DONE.
        resp1_ready = 1'b0;
        drive1(1'b1, INS_INST, 32'h0000_00AB, 32'hFFFF_FFFF, 4'd9);
        tick();
        req1_valid = 1'b0;
        drive0(1'b0, EXT_INST, 32'h1234_5678, 32'd0, 4'd8);
        tick();
        chk("fl_pre_resp1", {31'd0, resp1_valid}, 32'd1);
        chk("fl_pre_resp0", {31'd0, resp0_valid}, 32'd0);
        resp1_ready = 1'b1;
        flush = 1'b1;
        drive1(1'b1, INS_INST, 32'h0000_00AB, 32'hFFFF_FFFF, 4'd10);
        #1;
        chk("fl_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("fl_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        chk("fl_resp0_idle", {31'd0, resp0_valid}, 32'd0);
        chk("fl_resp1_idle", {31'd0, resp1_valid}, 32'd0);
        chk("fl_cnt_kept", {16'd0, conflict_cnt}, 32'd2);
        tick();
        chk("fl_no_late_resp0", {31'd0, resp0_valid}, 32'd0);
        chk("fl_no_late_resp1", {31'd0, resp1_valid}, 32'd0);
        tick();
        chk("fl_still_quiet", {31'd0, resp1_valid | resp0_valid}, 32'd0);

        // Reset while both pipes are waiting.
        drive0(1'b0, EXT_INST, 32'h1234_5678, 32'd0, 4'd1);
        drive1(1'b1, INS_INST, 32'h0000_00AB, 32'hFFFF_FFFF, 4'd2);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("mr_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("mr_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        chk("mr_resp1_valid", {31'd0, resp1_valid}, 32'd0);
        chk("mr_cnt", {16'd0, conflict_cnt}, 32'd0);
        chk("mr_bf_inst", bf_inst, 32'd0);
        chk("mr_resp0_data", resp0_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_stale", {31'd0, resp0_valid | resp1_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_bitfield_sched.md
EX_BITFIELD_SCHED -- requirements
Module: ex_bitfield_sched

Interface
REQ-001 SHALL have parameter TAG_W, default 4, meaning width of the per-request tag echoed with the response.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; one clock, synchronous and active-low.
REQ-004 SHALL have port flush  in  1  discard all pending and held work (pipeline flush).
REQ-005 SHALL have ports reqN_valid  in  1, reqN_ready  out  1, reqN_is_ins  in  1, reqN_inst  in  32, reqN_rs  in  32, reqN_rt  in  32, reqN_tag  in  TAG_W, for N in {0,1}; requester N is issue pipe N.
REQ-006 SHALL have ports respN_valid  out  1, respN_ready  in  1, respN_data  out  32, respN_tag  out  TAG_W, for N in {0,1}.
REQ-007 SHALL have ports bf_is_ins  out  1, bf_inst  out  32, bf_in1  out  32, bf_in2  out  32, bf_result  in  32; bf_result is a combinational function of the bf_* outputs from the shared EXT/INS unit.
REQ-008 SHALL have port conflict_cnt  out  16  saturating count of cycles with both pipes in WAIT.

Function
REQ-009 SHALL keep per pipe a 2-bit state: IDLE, WAIT (request captured, not executed), DONE (result held).
REQ-010 SHALL assert reqN_ready = (state==IDLE) | (state==DONE & respN_ready) & ~flush.
REQ-011 SHALL, on reqN_valid & reqN_ready, capture is_ins, inst, rs, rt, tag into pipe N's holding register and enter WAIT next cycle.
REQ-012 SHALL, each cycle, grant the shared unit to at most one pipe in WAIT; sole WAIT pipe wins; both WAIT -> round-robin pointer decides.
REQ-013 SHALL reset the round-robin pointer to pipe 0 and move it to the other pipe after every grant that occurred while both pipes were in WAIT; uncontested grants leave it unchanged.
REQ-014 SHALL drive bf_is_ins, bf_inst, bf_in1=rs, bf_in2=rt from the granted pipe's holding register; with no grant, drive all bf_* to 0.
REQ-015 SHALL capture bf_result and the tag into pipe N's result register at the end of its grant cycle and enter DONE.
REQ-016 SHALL assert respN_valid exactly when pipe N is in DONE; respN_data/respN_tag SHALL be stable while respN_valid & ~respN_ready.
REQ-017 SHALL, on respN_valid & respN_ready, go to WAIT if a new request is accepted in the same cycle, else IDLE.
REQ-018 SHALL give latency: accept at edge E -> grant in cycle after E -> respN_valid from second edge after E (2 cycles uncontested, 3 when losing arbitration once).
REQ-019 SHALL sustain one response per pipe every 2 cycles with respN_ready held high, and two results per 2 cycles overall.
REQ-020 SHALL, on flush, force both pipes to IDLE next cycle, ignore same-cycle requests (reqN_ready=0), drop any grant result, and leave round-robin pointer and conflict_cnt unchanged.
REQ-021 SHALL increment conflict_cnt by 1 each non-flush cycle with both pipes in WAIT, holding at 0xFFFF.
REQ-022 SHALL never grant a pipe in IDLE or DONE, and never grant both pipes in one cycle.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, set both states IDLE, pointer 0, conflict_cnt 0, result/holding registers 0; resp*_valid=0 and bf_* = 0 in the following cycle.
REQ-024 SHALL let reset mid-operation (WAIT or DONE) discard all work with no response ever issued for it.
REQ-025 SHALL keep req*_ready=0 during any cycle where rst_n=0.

Verification (bench attaches team EXT/INS datapath to bf_*)
REQ-026 SHALL cover: pipe0 EXT inst[15:11]=7, inst[10:6]=4, rs=0x12345678, tag=3 -> resp0_valid 2 cycles later, data 0x00000067, tag 3.
REQ-027 SHALL cover: pipe1 INS inst[15:11]=15, inst[10:6]=8, rs=0x000000AB, rt=0xFFFFFFFF -> resp1_data 0xFFFFABFF.
REQ-028 SHALL cover: both pipes accepted same edge -> pipe0 granted first, pipe1 one cycle later, conflict_cnt=1; repeat -> pipe1 granted first.
REQ-029 SHALL cover: resp0_ready=0 for 5 cycles -> resp0_valid/data stable, req0_ready=0, pipe1 traffic unaffected.
REQ-030 SHALL cover: flush while pipe0 WAIT and pipe1 DONE -> both IDLE next cycle, no responses, concurrent req dropped.
REQ-031 SHALL cover: rst_n=0 one cycle while both WAIT -> all outputs reset values, conflict_cnt=0, no stale response afterwards.
